// File: rtl/ex_mem_pkg.sv
// EX/MEM pipeline register shared types: payload bundle, skid-buffer state, counter helper.
package ex_mem_pkg;

   localparam int unsigned EX_MEM_DATA_W = 16;
   localparam int unsigned EX_MEM_REG_W  = 3;
   localparam int unsigned STAT_W        = 16;

   // One in-flight EX/MEM instruction: controls, flags and payload.
   typedef struct packed {
      logic                     mem_read;
      logic                     mem_write;
      logic                     branch;
      logic                     reg_write;
      logic                     mem_to_reg;
      logic                     zero;
      logic [EX_MEM_REG_W-1:0]  reg_dst;
      logic [EX_MEM_DATA_W-1:0] address;
      logic [EX_MEM_DATA_W-1:0] write_data;
      logic [EX_MEM_DATA_W-1:0] branch_target;
   } ex_mem_bundle_t;

   // Occupancy of the two-entry buffer.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_e;

   // Saturating add of a small increment onto a statistics counter.
   function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] a,
                                                 input logic [1:0]        b);
      logic [STAT_W:0] sum;
      sum = {1'b0, a} + (STAT_W+1)'(b);
      return sum[STAT_W] ? {STAT_W{1'b1}} : sum[STAT_W-1:0];
   endfunction

endpackage

// File: rtl/ex_mem_reg_pipe_slot.sv
// pipe_slot: a single bundle register with load enable and async clear.
module ex_mem_reg_pipe_slot
   import ex_mem_pkg::*;
(
   input  logic           clk_i,
   input  logic           rst_ni,
   input  logic           load_i,
   input  ex_mem_bundle_t data_i,
   output ex_mem_bundle_t data_o
);

   ex_mem_bundle_t data_q;

   // Capture the bundle when loaded; clear on reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         data_q <= '0;
      end else if (load_i) begin
         data_q <= data_i;
      end
   end

   assign data_o = data_q;

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: two-entry skid buffer with valid/ready on both sides,
// flush support and bubble gating of memory/branch controls.
// Optional: define EX_MEM_STATS_EN to add stall_cnt / flush_cnt statistics ports.
module ex_mem_reg
   import ex_mem_pkg::*;
#(
   parameter int unsigned DATA_W = EX_MEM_DATA_W,
   parameter int unsigned REG_W  = EX_MEM_REG_W
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              flush,
   input  logic              ex_valid,
   output logic              ex_ready,
   input  logic              ex_MemRead,
   input  logic              ex_MemWrite,
   input  logic              ex_Branch,
   input  logic              ex_RegWrite,
   input  logic              ex_MemToReg,
   input  logic              ex_Zero,
   input  logic [REG_W-1:0]  ex_RegDst,
   input  logic [DATA_W-1:0] ex_aluResult,
   input  logic [DATA_W-1:0] ex_writeData,
   input  logic [DATA_W-1:0] ex_branchTarget,
   input  logic              mem_ready,
   output logic              mem_valid,
   output logic              mem_MemRead,
   output logic              mem_MemWrite,
   output logic              mem_Branch,
   output logic              mem_RegWrite,
   output logic              mem_MemToReg,
   output logic              mem_Zero,
   output logic [REG_W-1:0]  mem_RegDst,
   output logic [DATA_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_writeData,
   output logic [DATA_W-1:0] mem_branchTarget
`ifdef EX_MEM_STATS_EN
   ,
   output logic [15:0]       stall_cnt,
   output logic [15:0]       flush_cnt
`endif
);

   state_e         state_q, state_d;
   logic           ex_ready_q, ex_ready_d;
   logic           mem_valid_q, mem_valid_d;
   logic           accept, consume;
   logic           load_main, load_skid, main_from_skid;
   ex_mem_bundle_t ex_bundle, main_d, main_q, skid_q;

   assign accept  = ex_valid & ex_ready_q;
   assign consume = mem_valid_q & mem_ready;

   // Pack the incoming EX stage signals into one bundle.
   always_comb begin
      ex_bundle               = '0;
      ex_bundle.mem_read      = ex_MemRead;
      ex_bundle.mem_write     = ex_MemWrite;
      ex_bundle.branch        = ex_Branch;
      ex_bundle.reg_write     = ex_RegWrite;
      ex_bundle.mem_to_reg    = ex_MemToReg;
      ex_bundle.zero          = ex_Zero;
      ex_bundle.reg_dst       = EX_MEM_REG_W'(ex_RegDst);
      ex_bundle.address       = EX_MEM_DATA_W'(ex_aluResult);
      ex_bundle.write_data    = EX_MEM_DATA_W'(ex_writeData);
      ex_bundle.branch_target = EX_MEM_DATA_W'(ex_branchTarget);
   end

   // Next-state and slot-load decode; flush overrides every other transition.
   always_comb begin
      state_d        = state_q;
      load_main      = 1'b0;
      load_skid      = 1'b0;
      main_from_skid = 1'b0;

      unique case (state_q)
         EMPTY: begin
            if (accept) begin
               state_d   = ONE;
               load_main = 1'b1;
            end
         end
         ONE: begin
            if (accept && consume) begin
               load_main = 1'b1;
            end else if (accept) begin
               state_d   = FULL;
               load_skid = 1'b1;
            end else if (consume) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (consume) begin
               state_d        = ONE;
               load_main      = 1'b1;
               main_from_skid = 1'b1;
            end
         end
         default: state_d = EMPTY;
      endcase

      if (flush) begin
         state_d        = EMPTY;
         load_main      = 1'b0;
         load_skid      = 1'b0;
         main_from_skid = 1'b0;
      end

      ex_ready_d  = (state_d != FULL);
      mem_valid_d = (state_d != EMPTY);
   end

   // State, upstream ready and downstream valid registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= EMPTY;
         ex_ready_q  <= 1'b0;
         mem_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ex_ready_q  <= ex_ready_d;
         mem_valid_q <= mem_valid_d;
      end
   end

   assign main_d = main_from_skid ? skid_q : ex_bundle;

   ex_mem_reg_pipe_slot u_main_slot (
      .clk_i  (clock),
      .rst_ni (reset_n),
      .load_i (load_main),
      .data_i (main_d),
      .data_o (main_q)
   );

   ex_mem_reg_pipe_slot u_skid_slot (
      .clk_i  (clock),
      .rst_ni (reset_n),
      .load_i (load_skid),
      .data_i (ex_bundle),
      .data_o (skid_q)
   );

   assign ex_ready  = ex_ready_q;
   assign mem_valid = mem_valid_q;

   // Controls are masked by valid so bubbles never touch memory or the PC.
   assign mem_MemRead  = main_q.mem_read   & mem_valid_q;
   assign mem_MemWrite = main_q.mem_write  & mem_valid_q;
   assign mem_Branch   = main_q.branch     & mem_valid_q;
   assign mem_RegWrite = main_q.reg_write  & mem_valid_q;
   assign mem_MemToReg = main_q.mem_to_reg & mem_valid_q;
   assign mem_Zero     = main_q.zero       & mem_valid_q;

   assign mem_RegDst       = REG_W'(main_q.reg_dst);
   assign mem_address      = DATA_W'(main_q.address);
   assign mem_writeData    = DATA_W'(main_q.write_data);
   assign mem_branchTarget = DATA_W'(main_q.branch_target);

`ifdef EX_MEM_STATS_EN
   logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [STAT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic [1:0]        flushed_n;

   // Count stalled cycles and valid entries thrown away by a flush.
   always_comb begin
      flushed_n   = 2'd0;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (flush) begin
         flushed_n = 2'(state_q == ONE) + 2'((state_q == FULL) ? 2'd2 : 2'd0) + 2'(accept);
      end
      if (mem_valid_q && !mem_ready) begin
         stall_cnt_d = sat_add(stall_cnt_q, 2'd1);
      end
      flush_cnt_d = sat_add(flush_cnt_q, flushed_n);
   end

   // Statistics registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`else
   // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// Scoreboard bench for ex_mem_reg: a queue-based FIFO model predicts ready/valid and
// the delivered bundle stream; a negedge monitor compares the DUT against it.
module tb_ex_mem_reg;

   typedef struct {
      bit        rd, wr, br, rw, m2r, z;
      bit [2:0]  dst;
      bit [15:0] addr, wdata, tgt;
   } item_t;

   logic        clock, reset_n, flush;
   logic        ex_valid, ex_ready;
   logic        ex_MemRead, ex_MemWrite, ex_Branch, ex_RegWrite, ex_MemToReg, ex_Zero;
   logic [2:0]  ex_RegDst;
   logic [15:0] ex_aluResult, ex_writeData, ex_branchTarget;
   logic        mem_ready, mem_valid;
   logic        mem_MemRead, mem_MemWrite, mem_Branch, mem_RegWrite, mem_MemToReg, mem_Zero;
   logic [2:0]  mem_RegDst;
   logic [15:0] mem_address, mem_writeData, mem_branchTarget;
`ifdef EX_MEM_STATS_EN
   logic [15:0] stall_cnt, flush_cnt;
`endif

   int    n_checks = 0;
   int    n_fail   = 0;
   int    n_delivered = 0;
   item_t exp_q[$];
   item_t h;
   bit    ready_m;
   bit    acc, cons;
   int unsigned stall_m, flush_m;

   ex_mem_reg dut (
      .clock            (clock),
      .reset_n          (reset_n),
      .flush            (flush),
      .ex_valid         (ex_valid),
      .ex_ready         (ex_ready),
      .ex_MemRead       (ex_MemRead),
      .ex_MemWrite      (ex_MemWrite),
      .ex_Branch        (ex_Branch),
      .ex_RegWrite      (ex_RegWrite),
      .ex_MemToReg      (ex_MemToReg),
      .ex_Zero          (ex_Zero),
      .ex_RegDst        (ex_RegDst),
      .ex_aluResult     (ex_aluResult),
      .ex_writeData     (ex_writeData),
      .ex_branchTarget  (ex_branchTarget),
      .mem_ready        (mem_ready),
      .mem_valid        (mem_valid),
      .mem_MemRead      (mem_MemRead),
      .mem_MemWrite     (mem_MemWrite),
      .mem_Branch       (mem_Branch),
      .mem_RegWrite     (mem_RegWrite),
      .mem_MemToReg     (mem_MemToReg),
      .mem_Zero         (mem_Zero),
      .mem_RegDst       (mem_RegDst),
      .mem_address      (mem_address),
      .mem_writeData    (mem_writeData),
      .mem_branchTarget (mem_branchTarget)
`ifdef EX_MEM_STATS_EN
      ,
      .stall_cnt        (stall_cnt),
      .flush_cnt        (flush_cnt)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic item_t cur_item();
      item_t it;
      it.rd = ex_MemRead;  it.wr = ex_MemWrite; it.br = ex_Branch;
      it.rw = ex_RegWrite; it.m2r = ex_MemToReg; it.z = ex_Zero;
      it.dst = ex_RegDst;  it.addr = ex_aluResult;
      it.wdata = ex_writeData; it.tgt = ex_branchTarget;
      return it;
   endfunction

   // Reference model: an in-order queue of at most two entries.
   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         exp_q.delete();
         ready_m = 1'b0;
         stall_m = 0;
         flush_m = 0;
      end else begin
         acc  = ex_valid && ready_m;
         cons = (exp_q.size() > 0) && mem_ready;
         if (exp_q.size() > 0 && !mem_ready && stall_m < 65535) stall_m++;
         if (flush) begin
            flush_m = flush_m + exp_q.size() + (acc ? 1 : 0);
            if (flush_m > 65535) flush_m = 65535;
            exp_q.delete();
         end else begin
            if (cons) begin
               void'(exp_q.pop_front());
               n_delivered++;
            end
            if (acc) exp_q.push_back(cur_item());
         end
         ready_m = (exp_q.size() < 2);
      end
   end

   // Monitor: compare DUT outputs with the model between clock edges.
   always @(negedge clock) begin
      check("ex_ready", ex_ready, ready_m);
      check("mem_valid", mem_valid, exp_q.size() > 0);
      if (exp_q.size() > 0) begin
         h = exp_q[0];
         check("ctrl", {mem_MemRead, mem_MemWrite, mem_Branch, mem_RegWrite, mem_MemToReg, mem_Zero},
               {h.rd, h.wr, h.br, h.rw, h.m2r, h.z});
         check("RegDst", mem_RegDst, h.dst);
         check("address", mem_address, h.addr);
         check("writeData", mem_writeData, h.wdata);
         check("branchTarget", mem_branchTarget, h.tgt);
      end else begin
         check("bubble_ctrl", {mem_MemRead, mem_MemWrite, mem_Branch, mem_RegWrite, mem_MemToReg, mem_Zero},
               6'd0);
      end
`ifdef EX_MEM_STATS_EN
      check("stall_cnt", stall_cnt, stall_m);
      check("flush_cnt", flush_cnt, flush_m);
`endif
   end

   // Drive one cycle of stimulus (other payload fields randomized), then wait a cycle.
   task automatic step(input bit v, input bit mr, input bit fl, input bit [15:0] alu,
                       input bit mw, input bit br);
      ex_valid        = v;
      mem_ready       = mr;
      flush           = fl;
      ex_aluResult    = alu;
      ex_MemWrite     = mw;
      ex_Branch       = br;
      ex_MemRead      = 1'($urandom);
      ex_RegWrite     = 1'($urandom);
      ex_MemToReg     = 1'($urandom);
      ex_Zero         = 1'($urandom);
      ex_RegDst       = 3'($urandom);
      ex_writeData    = 16'($urandom);
      ex_branchTarget = 16'($urandom);
      @(negedge clock);
   endtask

   initial begin
      reset_n = 1'b0;
      flush = 0; ex_valid = 0; mem_ready = 0;
      ex_MemRead = 0; ex_MemWrite = 0; ex_Branch = 0; ex_RegWrite = 0; ex_MemToReg = 0;
      ex_Zero = 0; ex_RegDst = 0; ex_aluResult = 0; ex_writeData = 0; ex_branchTarget = 0;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);

      // Streaming with no backpressure.
      step(1, 1, 0, 16'h0010, 0, 0);
      step(1, 1, 0, 16'h0020, 0, 0);
      step(1, 1, 0, 16'h0030, 0, 0);
      repeat (3) step(0, 1, 0, 16'h0000, 0, 0);

      // Backpressure fills both entries, then drains in order.
      step(1, 0, 0, 16'h00A1, 0, 0);
      step(1, 0, 0, 16'h00A2, 0, 0);
      step(1, 0, 0, 16'h00A3, 0, 0);
      repeat (3) step(0, 1, 0, 16'h0000, 0, 0);

      // Flush while full with a store presented.
      step(1, 0, 0, 16'h00B1, 1, 0);
      step(1, 0, 0, 16'h00B2, 1, 0);
      step(1, 0, 1, 16'h00B3, 1, 0);
      step(0, 0, 0, 16'h0000, 0, 0);

      // Flush in ONE with a same-cycle accept.
      step(1, 0, 0, 16'h00C1, 1, 1);
      step(1, 0, 1, 16'h00C2, 1, 1);

      // Bubbles carrying store/branch bits.
      repeat (3) step(0, 1, 0, 16'h0BAD, 1, 1);

      // Randomized traffic with an asynchronous reset in the middle.
      for (int i = 0; i < 600; i++) begin
         if (i == 300) begin
            #2 reset_n = 1'b0;
            #1;
            check("async_rst_valid", mem_valid, 1'b0);
            check("async_rst_ctrl", {mem_MemRead, mem_MemWrite, mem_Branch, mem_RegWrite, mem_MemToReg, mem_Zero},
                  6'd0);
            check("async_rst_ready", ex_ready, 1'b0);
            @(negedge clock);
            @(negedge clock);
            reset_n = 1'b1;
         end
         step(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6),
              ($urandom_range(0, 99) < 3), 16'($urandom), 1'($urandom), 1'($urandom));
      end

      repeat (4) step(0, 1, 0, 16'h0000, 0, 0);
      check("delivered_some", (n_delivered > 20), 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
